// File: rtl/calc_op_sequencer_if.sv
// ALU handshake bundle between the operation sequencer (master) and the ALU (slave).
interface calc_op_sequencer_if;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic        alu_done;
    logic [13:0] alu_result;

    modport master (
        output alu_start,
        output alu_op,
        input  alu_done,
        input  alu_result
    );

    modport slave (
        input  alu_start,
        input  alu_op,
        output alu_done,
        output alu_result
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// Button-driven operand entry and ALU operation sequencer with done-timeout.
// Optional macro CALC_DIV0_TRAP_EN: divide with n2==0 is trapped locally (err, result=3FFF) instead of issued.
module calc_op_sequencer #(
    parameter int MAX_OPERAND = 99,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8:0]          B,
    calc_op_sequencer_if.master alu,
    output logic [6:0]          n1,
    output logic [6:0]          n2,
    output logic [13:0]         result,
    output logic                busy,
    output logic                err,
    output logic [1:0]          state
);
    typedef enum logic [1:0] {
        ST_INPUT = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_SHOW  = 2'b11
    } state_t;

    localparam int               CNT_W       = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ALU_TIMEOUT - 1);
    localparam logic [6:0]       OPERAND_MAX = 7'(MAX_OPERAND);
    localparam logic [13:0]      DIV0_RESULT = 14'h3FFF;

    state_t           state_reg;
    logic [8:0]       b_prev_reg;
    logic [8:0]       btn_event;
    logic [6:0]       n1_reg;
    logic [6:0]       n2_reg;
    logic [6:0]       n1_next;
    logic [6:0]       n2_next;
    logic [13:0]      result_reg;
    logic [1:0]       alu_op_reg;
    logic [1:0]       op_sel;
    logic             alu_start_reg;
    logic             busy_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             op_hit;
    logic             op_accept;
    logic             div0_trap;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_edge
            assign btn_event[gi] = B[gi] & ~b_prev_reg[gi];
        end
    endgenerate

    // Saturating +/-1; simultaneous up and down leave the operand unchanged.
    function automatic logic [6:0] step_operand(input logic [6:0] v, input logic up, input logic down);
        logic [6:0] r;
        r = v;
        if (up && !down && (v < OPERAND_MAX)) begin
            r = v + 7'd1;
        end else if (down && !up && (v != 7'd0)) begin
            r = v - 7'd1;
        end
        return r;
    endfunction

    always_comb begin
        op_hit  = |btn_event[4:1];
        op_sel  = 2'b11;
        if (btn_event[4]) begin
            op_sel = 2'b00;
        end else if (btn_event[3]) begin
            op_sel = 2'b01;
        end else if (btn_event[2]) begin
            op_sel = 2'b10;
        end
        op_accept = op_hit && ((state_reg == ST_INPUT) || (state_reg == ST_SHOW));
        n1_next   = step_operand(n1_reg, btn_event[5], btn_event[7]);
        n2_next   = step_operand(n2_reg, btn_event[6], btn_event[8]);
    end

`ifdef CALC_DIV0_TRAP_EN
    assign div0_trap = (op_sel == 2'b11) && (n2_reg == 7'd0);
`else
    assign div0_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_INPUT;
            b_prev_reg    <= '0;
            n1_reg        <= '0;
            n2_reg        <= '0;
            result_reg    <= '0;
            alu_op_reg    <= 2'b00;
            alu_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            b_prev_reg    <= B;
            alu_start_reg <= 1'b0;
            if (op_accept) begin
                // An op event outranks enter and operand events in the same cycle.
                alu_op_reg <= op_sel;
                if (div0_trap) begin
                    err_reg    <= 1'b1;
                    result_reg <= DIV0_RESULT;
                    state_reg  <= ST_SHOW;
                end else begin
                    err_reg       <= 1'b0;
                    alu_start_reg <= 1'b1;
                    busy_reg      <= 1'b1;
                    state_reg     <= ST_ISSUE;
                end
            end else begin
                case (state_reg)
                    ST_INPUT: begin
                        if (btn_event[0]) begin
                            n1_reg <= '0;
                            n2_reg <= '0;
                        end else begin
                            n1_reg <= n1_next;
                            n2_reg <= n2_next;
                        end
                    end
                    ST_ISSUE: begin
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // A done arriving on the last permitted cycle still wins over the timeout.
                        if (alu.alu_done) begin
                            result_reg <= alu.alu_result;
                            busy_reg   <= 1'b0;
                            state_reg  <= ST_SHOW;
                        end else if (cnt_reg == CNT_LAST) begin
                            err_reg    <= 1'b1;
                            result_reg <= '0;
                            busy_reg   <= 1'b0;
                            state_reg  <= ST_SHOW;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    ST_SHOW: begin
                        if (btn_event[0]) begin
                            state_reg <= ST_INPUT;
                        end
                    end
                    default: begin
                        state_reg <= ST_INPUT;
                    end
                endcase
            end
        end
    end

    assign alu.alu_start = alu_start_reg;
    assign alu.alu_op    = alu_op_reg;
    assign n1            = n1_reg;
    assign n2            = n2_reg;
    assign result        = result_reg;
    assign busy          = busy_reg;
    assign err           = err_reg;
    assign state         = state_reg;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: randomized buttons and ALU responses against a behavioural model.
module tb_calc_op_sequencer;
    localparam int MAXO = 99;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  B;
    logic [6:0]  n1;
    logic [6:0]  n2;
    logic [13:0] result;
    logic        busy;
    logic        err;
    logic [1:0]  state;

    int compared   = 0;
    int mismatched = 0;
    int start_cnt  = 0;

    int m_n1;
    int m_n2;
    int m_result;
    bit m_err;
    int m_state;

    calc_op_sequencer_if ifc ();

    calc_op_sequencer #(.MAX_OPERAND(MAXO), .ALU_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .B(B), .alu(ifc),
        .n1(n1), .n2(n2), .result(result), .busy(busy), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (ifc.alu_start === 1'b1) start_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat_step(input int v, input bit up, input bit down);
        int r;
        r = v + (up ? 1 : 0) - (down ? 1 : 0);
        if (r > MAXO) r = MAXO;
        if (r < 0) r = 0;
        return r;
    endfunction

    function automatic int expected_op(input logic [8:0] mask);
        // add(B4) > sub(B3) > mul(B2) > div(B1)
        for (int k = 0; k < 4; k++) if (mask[4-k]) return k;
        return -1;
    endfunction

    // Non-op button pulse, one cycle wide; model follows the INPUT/SHOW rules.
    task automatic press(input logic [8:0] mask);
        @(negedge clk); B = mask;
        @(negedge clk); B = '0;
        if (m_state == 0) begin
            if (mask[0]) begin
                m_n1 = 0; m_n2 = 0;
            end else begin
                m_n1 = sat_step(m_n1, mask[5], mask[7]);
                m_n2 = sat_step(m_n2, mask[6], mask[8]);
            end
        end else if (m_state == 3 && mask[0]) begin
            m_state = 0;
        end
    endtask

    task automatic run_op(input logic [8:0] mask, input bit respond, input int delay,
                          input logic [13:0] val, input string tag);
        int s0, code, k;
        bit trap;
        code = expected_op(mask);
        s0 = start_cnt;
        trap = 1'b0;
`ifdef CALC_DIV0_TRAP_EN
        trap = (code == 3) && (m_n2 == 0);
`endif
        @(negedge clk); B = mask;
        @(negedge clk); B = '0;
        if (trap) begin
            compared++;
            if (ifc.alu_start !== 1'b0) begin mismatched++; $display("FAIL %s trap_no_start: got %b want 0", tag, ifc.alu_start); end
            m_err = 1'b1; m_result = 14'h3FFF; m_state = 3;
        end else begin
            compared++;
            if (state !== 2'd1) begin mismatched++; $display("FAIL %s issue_state: got %0d want 1", tag, state); end
            compared++;
            if (ifc.alu_start !== 1'b1) begin mismatched++; $display("FAIL %s start_latency: got %b want 1", tag, ifc.alu_start); end
            compared++;
            if (ifc.alu_op !== 2'(code)) begin mismatched++; $display("FAIL %s alu_op: got %0d want %0d", tag, ifc.alu_op, code); end
            compared++;
            if (busy !== 1'b1) begin mismatched++; $display("FAIL %s busy_issue: got %b want 1", tag, busy); end
            if (respond) begin
                repeat (delay) @(negedge clk);
                compared++;
                if (state !== 2'd2 || ifc.alu_op !== 2'(code)) begin
                    mismatched++; $display("FAIL %s wait_hold: state %0d op %0d want 2/%0d", tag, state, ifc.alu_op, code);
                end
                ifc.alu_result = val; ifc.alu_done = 1'b1;
                @(negedge clk);
                ifc.alu_done = 1'b0; ifc.alu_result = 14'($urandom);
                m_result = val; m_err = 1'b0; m_state = 3;
            end else begin
                k = 0;
                for (int i = 1; i <= 40; i++) begin
                    @(negedge clk);
                    if (state === 2'd3) begin k = i; break; end
                    B = (i == 3) ? 9'($urandom_range(1, 511)) : 9'd0;
                end
                B = '0;
                compared++;
                if (k != TO + 1) begin mismatched++; $display("FAIL %s timeout_cycles: got %0d want %0d", tag, k, TO + 1); end
                m_result = 0; m_err = 1'b1; m_state = 3;
            end
        end
        compared++;
        if (state !== 2'(m_state)) begin mismatched++; $display("FAIL %s end_state: got %0d want %0d", tag, state, m_state); end
        compared++;
        if (result !== 14'(m_result)) begin mismatched++; $display("FAIL %s result: got %0d want %0d", tag, result, m_result); end
        compared++;
        if (err !== m_err) begin mismatched++; $display("FAIL %s err: got %b want %b", tag, err, m_err); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL %s busy_end: got %b want 0", tag, busy); end
        compared++;
        if (n1 !== 7'(m_n1) || n2 !== 7'(m_n2)) begin
            mismatched++; $display("FAIL %s operands: got %0d/%0d want %0d/%0d", tag, n1, n2, m_n1, m_n2);
        end
        compared++;
        if (start_cnt - s0 != (trap ? 0 : 1)) begin
            mismatched++; $display("FAIL %s start_pulses: got %0d want %0d", tag, start_cnt - s0, trap ? 0 : 1);
        end
        $display("op %s: mask=%h op=%0d n1=%0d n2=%0d result=%0d err=%b", tag, mask, code, n1, n2, result, err);
    endtask

    task automatic test_reset();
        rst = 1'b0; B = '0; ifc.alu_done = 1'b0; ifc.alu_result = '0;
        repeat (3) @(negedge clk);
        compared++;
        if (state !== 2'd0 || busy !== 1'b0 || err !== 1'b0) begin
            mismatched++; $display("FAIL reset_flags: state %0d busy %b err %b want 0/0/0", state, busy, err);
        end
        compared++;
        if (n1 !== 7'd0 || n2 !== 7'd0 || result !== 14'd0) begin
            mismatched++; $display("FAIL reset_data: n1 %0d n2 %0d result %0d want 0", n1, n2, result);
        end
        compared++;
        if (ifc.alu_start !== 1'b0 || ifc.alu_op !== 2'b00) begin
            mismatched++; $display("FAIL reset_alu: start %b op %0d want 0/0", ifc.alu_start, ifc.alu_op);
        end
        rst = 1'b1;
        m_n1 = 0; m_n2 = 0; m_result = 0; m_err = 1'b0; m_state = 0;
        $display("reset: state=%0d n1=%0d n2=%0d", state, n1, n2);
    endtask

    task automatic test_operand_entry();
        int s0;
        s0 = start_cnt;
        repeat (10) press(9'h020);
        repeat (10) press(9'h040);
        compared++;
        if (n1 !== 7'd10 || n2 !== 7'd10) begin mismatched++; $display("FAIL entry_operands: got %0d/%0d want 10/10", n1, n2); end
        compared++;
        if (state !== 2'd0 || start_cnt != s0) begin
            mismatched++; $display("FAIL entry_idle: state %0d starts %0d want 0/0", state, start_cnt - s0);
        end
        $display("entry: n1=%0d n2=%0d", n1, n2);
    endtask

    task automatic test_show_reissue();
        run_op(9'h010, 1'b1, $urandom_range(1, TO), 14'($urandom), "add");
        run_op(9'h008, 1'b1, $urandom_range(1, TO), 14'($urandom), "sub");
        run_op(9'h002, 1'b1, $urandom_range(1, TO), 14'($urandom), "div");
        press(9'h001);
        compared++;
        if (state !== 2'd0 || n1 !== 7'(m_n1) || n2 !== 7'(m_n2) || result !== 14'(m_result)) begin
            mismatched++;
            $display("FAIL show_return: state %0d n1 %0d n2 %0d result %0d want 0/%0d/%0d/%0d", state, n1, n2, result, m_n1, m_n2, m_result);
        end
        $display("return: state=%0d n1=%0d n2=%0d result=%0d", state, n1, n2, result);
    endtask

    task automatic test_saturation();
        press(9'h001);
        repeat (102) press(9'h020);
        compared++;
        if (n1 !== 7'd99) begin mismatched++; $display("FAIL sat_high: got %0d want 99", n1); end
        press(9'h0A0);
        compared++;
        if (n1 !== 7'd99) begin mismatched++; $display("FAIL cancel_n1: got %0d want 99", n1); end
        press(9'h080);
        compared++;
        if (n1 !== 7'd98) begin mismatched++; $display("FAIL dec_n1: got %0d want 98", n1); end
        press(9'h001);
        press(9'h080);
        press(9'h100);
        compared++;
        if (n1 !== 7'd0 || n2 !== 7'd0) begin mismatched++; $display("FAIL sat_low: got %0d/%0d want 0/0", n1, n2); end
        press(9'h040);
        press(9'h140);
        compared++;
        if (n2 !== 7'(m_n2)) begin mismatched++; $display("FAIL cancel_n2: got %0d want %0d", n2, m_n2); end
        $display("saturation: n1=%0d n2=%0d", n1, n2);
    endtask

    task automatic test_random_operands();
        logic [8:0] prev, cur, ev;
        prev = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            compared++;
            if (n1 !== 7'(m_n1) || n2 !== 7'(m_n2)) begin
                mismatched++; $display("FAIL rand_operands[%0d]: got %0d/%0d want %0d/%0d", i, n1, n2, m_n1, m_n2);
            end
            cur = {4'($urandom), 4'b0000, ($urandom_range(0, 15) == 0)};
            B = cur;
            ev = cur & ~prev;
            if (ev[0]) begin
                m_n1 = 0; m_n2 = 0;
            end else begin
                m_n1 = sat_step(m_n1, ev[5], ev[7]);
                m_n2 = sat_step(m_n2, ev[6], ev[8]);
            end
            prev = cur;
        end
        @(negedge clk); B = '0;
        @(negedge clk);
        compared++;
        if (n1 !== 7'(m_n1) || n2 !== 7'(m_n2)) begin
            mismatched++; $display("FAIL rand_final: got %0d/%0d want %0d/%0d", n1, n2, m_n1, m_n2);
        end
        $display("random entry: n1=%0d n2=%0d", n1, n2);
    endtask

    task automatic test_priority();
        logic [8:0] mask;
        for (int i = 0; i < 6; i++) begin
            mask = {4'($urandom), 4'($urandom_range(1, 15)), 1'($urandom)};
            run_op(mask, 1'b1, $urandom_range(1, TO), 14'($urandom), "prio");
            press(9'h001);
        end
    endtask

    task automatic test_reset_midop();
        int s0;
        s0 = start_cnt;
        press(9'h020);
        press(9'h040);
        @(negedge clk); B = 9'h004;
        @(negedge clk); B = 9'h020;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++;
        if (state !== 2'd0 || busy !== 1'b0 || err !== 1'b0 || ifc.alu_start !== 1'b0) begin
            mismatched++; $display("FAIL async_reset_flags: state %0d busy %b err %b start %b", state, busy, err, ifc.alu_start);
        end
        compared++;
        if (n1 !== 7'd0 || n2 !== 7'd0 || result !== 14'd0) begin
            mismatched++; $display("FAIL async_reset_data: n1 %0d n2 %0d result %0d want 0", n1, n2, result);
        end
        @(negedge clk);
        rst = 1'b1;
        ifc.alu_done = 1'b1; ifc.alu_result = 14'h1234;
        @(negedge clk);
        ifc.alu_done = 1'b0;
        compared++;
        if (n1 !== 7'd1 || state !== 2'd0 || result !== 14'd0) begin
            mismatched++; $display("FAIL held_button_release: n1 %0d state %0d result %0d want 1/0/0", n1, state, result);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (n1 !== 7'd1) begin mismatched++; $display("FAIL held_single_event: got %0d want 1", n1); end
        B = '0;
        compared++;
        if (start_cnt - s0 != 1) begin mismatched++; $display("FAIL reset_starts: got %0d want 1", start_cnt - s0); end
        m_n1 = 1; m_n2 = 0; m_result = 0; m_err = 1'b0; m_state = 0;
        $display("reset mid-op: state=%0d n1=%0d result=%0d", state, n1, result);
    endtask

    initial begin
        test_reset();
        test_operand_entry();
        run_op(9'h004, 1'b1, 3, 14'd100, "mul");
        test_show_reissue();
        run_op(9'h004, 1'b0, 0, 14'd0, "timeout");
        run_op(9'h010, 1'b1, TO, 14'($urandom), "done_at_limit");
        press(9'h001);
        test_saturation();
        test_random_operands();
        test_priority();
        press(9'h001);
        run_op(9'h002, 1'b1, $urandom_range(1, TO), 14'($urandom), "div_n2_zero");
        press(9'h001);
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
